// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle.
// Latency: start at edge T, done and result visible in cycle T+DATA_WIDTH+1.
// Backpressure: stall_request freezes the pipeline while iterating; flush aborts.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  stall_request,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    opb_q, mplr_q, raw1_q, hi_q, lo_q;
  logic            neg_q, rneg_q, dz_q, is_div_q;

  logic            sgn_1, sgn_2;
  logic [W-1:0]    mag_1, mag_2, res_hi, res_lo;
  logic [W:0]      mul_sum, div_diff;
  logic [2*W-1:0]  mul_next, div_next, prod;

  assign sgn_1 = ~op[0] & operand_1[W-1];
  assign sgn_2 = ~op[0] & operand_2[W-1];
  assign mag_1 = sgn_1 ? -operand_1 : operand_1;
  assign mag_2 = sgn_2 ? -operand_2 : operand_2;

  // acc holds {partial product, shifted-out low bits} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplr_q[0] ? opb_q : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[W-1:1]};
  assign div_diff = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opb_q};
  assign div_next = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                                : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
  assign prod     = neg_q ? -acc_q : acc_q;

  always_comb begin
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        res_hi = raw1_q;
        res_lo = {W{1'b1}};
      end else begin
        res_hi = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        res_lo = neg_q  ? -acc_q[W-1:0]   : acc_q[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = op[1] ? S_DIV : S_MUL;
        S_MUL,
        S_DIV:    if (cnt_q == LAST) state_d = S_FINISH;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Result is forwarded in the done cycle so the consumer sees it without waiting for the HI/LO write
  always_comb begin
    stall_request = (state_q == S_IDLE && start && !flush) ||
                    state_q == S_MUL || state_q == S_DIV;
    done          = (state_q == S_FINISH) && !flush;
    hi            = done ? res_hi : hi_q;
    lo            = done ? res_lo : lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      mplr_q   <= '0;
      raw1_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wr_data;
          if (lo_we) lo_q <= wr_data;
          if (start) begin
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q    <= sgn_1 ^ sgn_2;
            rneg_q   <= sgn_1;
            dz_q     <= (operand_2 == '0);
            raw1_q   <= operand_1;
            opb_q    <= op[1] ? mag_2 : mag_1;
            mplr_q   <= mag_2;
            acc_q    <= op[1] ? {{W{1'b0}}, mag_1} : '0;
          end
        end
        S_MUL: begin
          acc_q  <= mul_next;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
        S_FINISH: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: cnt_q <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] operand_1, operand_2, wr_data;
  logic        stall_request, done;
  logic [31:0] hi, lo;

  int nchk = 0;
  int nerr = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .stall_request(stall_request), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: returns {hi, lo} using plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = sa * sb;
      2'd1: res = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int mthi_at);
    int stalls = 0;
    int done_at = 0;
    logic [31:0] rh = 32'h0;
    logic [31:0] rl = 32'h0;
    op = o; operand_1 = a; operand_2 = b; start = 1'b1;
    #1 check({name, ":stall_T"}, stall_request, 1);
    @(posedge clk); #1;
    start = 1'b0;
    operand_1 = $urandom;
    operand_2 = $urandom;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      hi_we = (k == mthi_at);
      wr_data = 32'hDEAD_BEEF;
      #1;
      if (stall_request) stalls++;
      if (done) begin
        done_at = k;
        rh = hi;
        rl = lo;
        check({name, ":stall_in_done"}, stall_request, 0);
      end
      @(posedge clk); #1;
    end
    hi_we = 1'b0;
    check({name, ":latency"}, done_at, 33);
    check({name, ":stall_cycles"}, stalls, 32);
    check({name, ":hi"}, rh, eh);
    check({name, ":lo"}, rl, el);
    #1;
    check({name, ":done_once"}, done, 0);
    check({name, ":hold_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin : main
    vec_t tbl[9];
    logic [63:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int ndone;

    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6] = '{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    tbl[7] = '{2'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tbl[8] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; operand_1 = '0; operand_2 = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset:stall", stall_request, 0);
    check("reset:done", done, 0);
    check("reset:hilo", {hi, lo}, 64'h0);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {1'b1, 31'($urandom_range(0, 15))};
      m = model(ro, ra, rb);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, m[63:32], m[31:0], 0);
    end

    lo_we = 1'b1; wr_data = 32'h55;
    @(posedge clk); #1;
    lo_we = 1'b0;
    #1 check("mtlo", lo, 32'h55);

    hi_we = 1'b1; wr_data = 32'hAA;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'hBB;
    @(posedge clk); #1;
    lo_we = 1'b0;
    op = 2'd3; operand_1 = 32'd1000; operand_2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush:done_low", done, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush:idle_stall", stall_request, 0);
    check("flush:no_done", done, 0);
    check("flush:hilo_kept", {hi, lo}, {32'hAA, 32'hBB});
    run_op("after_flush", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 0);

    run_op("mthi_in_mul", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5);

    op = 2'd1; operand_1 = 32'h1234_5678; operand_2 = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid:hilo", {hi, lo}, 64'h0);
    check("rst_mid:stall", stall_request, 0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_mid:no_done", ndone, 0);
    check("rst_mid:hilo_after", {hi, lo}, 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage.
- Consumes operand_1/operand_2 as produced by ID operand generation for SPECIAL-class MULT/MULTU/DIV/DIVU, and owns the architectural HI/LO registers.
- Iterative: one bit per cycle, so 32 iteration cycles per operation.
- Raises stall_request to freeze the pipeline while computing; supports MTHI/MTLO writes and flush.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- start  input  1  request new operation; sampled only in IDLE
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- operand_1  input  32  multiplicand / dividend
- operand_2  input  32  multiplier / divisor
- flush  input  1  abort in-flight operation
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wr_data  input  32  MTHI/MTLO data
- stall_request  output  1  pipeline freeze request
- done  output  1  one-cycle completion pulse
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, hi=0, lo=0, done=0, counter=0. Reset mid-operation aborts with no HI/LO update.
- States: IDLE, MUL, DIV, FINISH.
- IDLE -> MUL/DIV on start (op[1] selects DIV).
  - Latch |operand_1| and |operand_2| for signed ops (raw values for unsigned).
  - Latch result-sign flags: quotient/product sign = s1^s2, remainder sign = s1.
  - Latch the divisor-zero flag and raw operand_1; clear counter.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial-remainder subtract.
- After 32 iteration cycles, go to FINISH.
- FINISH:
  - Apply sign correction (two's-complement negate where the flag is set).
  - Write hi/lo at the clock edge and assert done for exactly one cycle.
  - Return to IDLE.
- Latency: start sampled at edge T, done high during cycle T+33, hi/lo show the result from that same cycle and hold until the next write.
- Product: hi=upper 32 bits, lo=lower 32 bits.
- Quotient and remainder: lo=quotient, hi=remainder.
- stall_request = (state==IDLE && start && !flush) || state==MUL || state==DIV. Deasserted in FINISH so the pipeline advances in the done cycle.
- start while not IDLE: ignored.
- Divisor zero:
  - Takes the full 33 cycles.
  - lo=0xFFFFFFFF and hi=raw operand_1, with no sign correction (DIV and DIVU alike).
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural 32-bit wrap, no trap).
- flush:
  - In any state, the next state is IDLE; the counter clears, hi/lo are unchanged and done=0.
  - flush with start in IDLE: start is ignored.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored in MUL/DIV/FINISH.
  - With start in the same IDLE cycle, the write is applied and the operation starts; the FINISH result later overwrites it.
- done and stall_request are never high in the same cycle.
- flush has priority over start and over hi_we/lo_we.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at T+33, hi=0xFFFFFFFE, lo=0x00000001; stall_request high for exactly cycles T..T+32.
- MULT 0xFFFFFFFD(-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 ÷ 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 ÷ 7 -> lo=14, hi=2; DIV 0x80000000 ÷ -1 -> lo=0x80000000, hi=0.
- DIVU 0x1234 ÷ 0 and DIV -5 ÷ 0 -> lo=0xFFFFFFFF, hi=0x1234 and 0xFFFFFFFB respectively; no hang.
- Flush at cycle T+10 of a DIVU with prior hi=0xAA, lo=0xBB -> IDLE next cycle, no done, hi/lo remain 0xAA/0xBB; a new start is accepted the cycle after.
- MTLO 0x55 in IDLE -> lo=0x55 next cycle; MTHI asserted during MUL -> ignored. rst asserted mid-MUL -> hi=lo=0, done never pulses.
